// File: rtl/wb_ctrl_if.sv
// Writeback controller bus: ALU result, LSU result handshake, issue
// notification, register-file write port and pending-write scoreboard.
interface wb_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_alu_valid;
  logic [4:0]      i_alu_rd;
  logic [XLEN-1:0] i_alu_data;
  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic [4:0]      i_lsu_rd;
  logic [XLEN-1:0] i_lsu_data;
  logic            i_issue_flag;
  logic [4:0]      i_issue_rd;
  logic            o_write_flag;
  logic [4:0]      o_write_addr;
  logic [XLEN-1:0] o_write_data;
  logic [31:0]     o_pending;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_lsu_valid, i_lsu_rd, i_lsu_data,
    input  i_issue_flag, i_issue_rd,
    output o_lsu_ready, o_write_flag, o_write_addr, o_write_data, o_pending
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_lsu_valid, i_lsu_rd, i_lsu_data,
    output i_issue_flag, i_issue_rd,
    input  o_lsu_ready, o_write_flag, o_write_addr, o_write_data, o_pending
  );
endinterface

// File: rtl/wb_ctrl.sv
// Writeback controller: ALU-priority arbitration against a small LSU result
// buffer onto the single register-file write port, plus a pending-write scoreboard.
module wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  wb_ctrl_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [4:0]      rd_mem_r   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_r, rptr_r;
  logic [CNT_W-1:0] count_r, count_s;
  logic             ready_r;
  logic             alu_take_s, push_s, pop_s;
  logic             load_s;
  logic [4:0]       load_rd_s;
  logic [XLEN-1:0]  load_data_s;
  logic [31:0]      pending_s;
  logic             flag_r;
  logic [4:0]       addr_r;
  logic [XLEN-1:0]  data_r;
  logic [31:0]      pending_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign bus.o_lsu_ready  = ready_r;
  assign bus.o_write_flag = flag_r;
  assign bus.o_write_addr = addr_r;
  assign bus.o_write_data = data_r;
  assign bus.o_pending    = pending_r;

  // Source selection: ALU first, FIFO head only when the ALU has no real write; x0 results vanish here.
  always_comb begin
    alu_take_s  = bus.i_alu_valid && (bus.i_alu_rd != 5'd0);
    push_s      = bus.i_lsu_valid && ready_r && (bus.i_lsu_rd != 5'd0);
    pop_s       = (count_r != {CNT_W{1'b0}}) && !alu_take_s;
    load_s      = 1'b0;
    load_rd_s   = addr_r;
    load_data_s = data_r;
    if (alu_take_s) begin
      load_s      = 1'b1;
      load_rd_s   = bus.i_alu_rd;
      load_data_s = bus.i_alu_data;
    end else if (pop_s) begin
      load_s      = 1'b1;
      load_rd_s   = rd_mem_r[rptr_r];
      load_data_s = data_mem_r[rptr_r];
    end else begin
      load_s      = 1'b0;
    end
  end

  // Next FIFO occupancy and scoreboard; a set on the same rd as the clear wins by ordering.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
    pending_s = pending_r;
    if (load_s) begin
      pending_s[load_rd_s] = 1'b0;
    end else begin
      pending_s = pending_r;
    end
    if (bus.i_issue_flag && (bus.i_issue_rd != 5'd0)) begin
      pending_s[bus.i_issue_rd] = 1'b1;
    end else begin
      pending_s[0] = 1'b0;
    end
    pending_s[0] = 1'b0;
  end

  // Buffer storage; entries need no reset because pointers and count gate their use.
  always_ff @(posedge clk) begin
    if (push_s) begin
      rd_mem_r[wptr_r]   <= bus.i_lsu_rd;
      data_mem_r[wptr_r] <= bus.i_lsu_data;
    end
  end

  // Control state, output register and scoreboard.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r   <= {CNT_W{1'b0}};
      wptr_r    <= {PTR_W{1'b0}};
      rptr_r    <= {PTR_W{1'b0}};
      ready_r   <= 1'b1;
      flag_r    <= 1'b0;
      addr_r    <= 5'd0;
      data_r    <= {XLEN{1'b0}};
      pending_r <= 32'd0;
    end else begin
      count_r   <= count_s;
      ready_r   <= (count_s < CNT_W'(FIFO_DEPTH));
      if (push_s) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      flag_r    <= load_s;
      addr_r    <= load_rd_s;
      data_r    <= load_data_s;
      pending_r <= pending_s;
    end
  end
endmodule

// File: tb/tb_wb_ctrl.sv
// Directed table-driven bench for wb_ctrl plus hand-written reset sequences.
module tb_wb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_ctrl_if #(.XLEN(32)) bus ();

  wb_ctrl #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        e_flag;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic        e_ready;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ar, input logic [31:0] ad,
    input logic lv, input logic [4:0] lr, input logic [31:0] ld,
    input logic iv, input logic [4:0] ir,
    input logic ef, input logic [4:0] ea, input logic [31:0] ed,
    input logic [31:0] ep, input logic er);
    vec_t v;
    v.alu_v = av; v.alu_rd = ar; v.alu_d = ad;
    v.lsu_v = lv; v.lsu_rd = lr; v.lsu_d = ld;
    v.iss_v = iv; v.iss_rd = ir;
    v.e_flag = ef; v.e_addr = ea; v.e_data = ed; v.e_pend = ep; v.e_ready = er;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ir);
    bus.i_alu_valid  = av; bus.i_alu_rd = ar; bus.i_alu_data = ad;
    bus.i_lsu_valid  = lv; bus.i_lsu_rd = lr; bus.i_lsu_data = ld;
    bus.i_issue_flag = iv; bus.i_issue_rd = ir;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic ef, input logic [4:0] ea,
                            input logic [31:0] ed, input logic [31:0] ep, input logic er);
    check({tag, "_flag"},  idx, {31'd0, bus.o_write_flag}, {31'd0, ef});
    check({tag, "_addr"},  idx, {27'd0, bus.o_write_addr}, {27'd0, ea});
    check({tag, "_data"},  idx, bus.o_write_data, ed);
    check({tag, "_pend"},  idx, bus.o_pending, ep);
    check({tag, "_ready"}, idx, {31'd0, bus.o_lsu_ready}, {31'd0, er});
  endtask

  initial begin
    // Expected values are the register state right after the edge on which the inputs were applied.
    vecs[0]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0,    1'b1);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0,    1'b1);
    vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd12, 1'b0, 5'd5,  32'hDEADBEEF, 32'h1000, 1'b1);
    vecs[3]  = mk(1'b1, 5'd12, 32'h12,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b1, 5'd12, 32'h12,       32'h0,    1'b1);
    vecs[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd12, 1'b0, 5'd12, 32'h12,       32'h1000, 1'b1);
    vecs[5]  = mk(1'b1, 5'd12, 32'h34,       1'b0, 5'd0, 32'h0,  1'b1, 5'd12, 1'b1, 5'd12, 32'h34,       32'h1000, 1'b1);
    vecs[6]  = mk(1'b1, 5'd12, 32'h56,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b1, 5'd12, 32'h56,       32'h0,    1'b1);
    vecs[7]  = mk(1'b1, 5'd0,  32'hFF,       1'b1, 5'd0, 32'hAA, 1'b1, 5'd0,  1'b0, 5'd12, 32'h56,       32'h0,    1'b1);
    vecs[8]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b0, 5'd12, 32'h56,       32'h0,    1'b1);
    vecs[9]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'h77, 1'b0, 5'd0,  1'b0, 5'd12, 32'h56,       32'h0,    1'b1);
    vecs[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b1, 5'd3,  32'h77,       32'h0,    1'b1);
    vecs[11] = mk(1'b1, 5'd1,  32'hA1,       1'b1, 5'd7, 32'h11, 1'b1, 5'd7,  1'b1, 5'd1,  32'hA1,       32'h80,   1'b1);
    vecs[12] = mk(1'b1, 5'd2,  32'hA2,       1'b1, 5'd8, 32'h22, 1'b0, 5'd0,  1'b1, 5'd2,  32'hA2,       32'h80,   1'b0);
    vecs[13] = mk(1'b1, 5'd3,  32'hA3,       1'b1, 5'd9, 32'h33, 1'b0, 5'd0,  1'b1, 5'd3,  32'hA3,       32'h80,   1'b0);
    vecs[14] = mk(1'b1, 5'd4,  32'hA4,       1'b1, 5'd9, 32'h33, 1'b0, 5'd0,  1'b1, 5'd4,  32'hA4,       32'h80,   1'b0);
    vecs[15] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h33, 1'b0, 5'd0,  1'b1, 5'd7,  32'h11,       32'h0,    1'b1);
    vecs[16] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h33, 1'b0, 5'd0,  1'b1, 5'd8,  32'h22,       32'h0,    1'b1);
    vecs[17] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b1, 5'd9,  32'h33,       32'h0,    1'b1);
    vecs[18] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  1'b0, 5'd9,  32'h33,       32'h0,    1'b1);

    // Reset held 3 cycles while inputs toggle.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 5'd5, 32'hCAFE0000 + 32'(i), ~i[0], 5'd6, 32'h1234, 1'b1, 5'd10 + 5'(i));
      @(posedge clk); #1;
    end
    check_outs("reset", 0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    @(posedge clk); #1;
    check_outs("post_reset", 0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d, vecs[i].lsu_v, vecs[i].lsu_rd,
            vecs[i].lsu_d, vecs[i].iss_v, vecs[i].iss_rd);
      @(posedge clk); #1;
      check_outs("vec", i, vecs[i].e_flag, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_pend, vecs[i].e_ready);
    end

    // Mid-operation reset: fill the buffer behind ALU traffic, pending = 0x1080.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hC1, 1'b1, 5'd7);
    @(posedge clk); #1;
    check_outs("fill_a", 0, 1'b1, 5'd1, 32'h1, 32'h80, 1'b1);
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd14, 32'hC2, 1'b1, 5'd12);
    @(posedge clk); #1;
    check_outs("fill_b", 0, 1'b1, 5'd2, 32'h2, 32'h1080, 1'b0);
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd15, 32'hC3, 1'b1, 5'd3);
    @(posedge clk); #1;
    check_outs("mid_reset", 0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outs("after_reset", i, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
